circle_ctrl: RTL

Sequencing FSM for the midpoint-circle datapath that drives the VGA adapter. On `start` it optionally sweeps the 160x120 screen to black, then initialises the datapath, steps it through the 8-octant plot loop and the error/offset update until the datapath reports the arc complete. It then holds `done` until `start` is released. It owns only control and the clear-sweep counters. All coordinate and error arithmetic stays in the datapath.

---
 rtl/circle_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/circle_ctrl.sv
// Control FSM for the midpoint-circle datapath: optional black clear sweep,
// then the 8-octant plot loop with offset/error update until the arc closes.
module circle_ctrl #(
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       clear_en,
  input  logic       oct_last,
  input  logic       crit_pos,
  input  logic       loop_done,
  output logic       init,
  output logic       xy_load,
  output logic       oct_en,
  output logic       oct_clr,
  output logic       y_off_en,
  output logic       x_off_en,
  output logic       crit_en,
  output logic       crit_sel,
  output logic       pix_sel,
  output logic [7:0] clr_x,
  output logic [6:0] clr_y,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] XLAST = 8'(XMAX);
  localparam logic [6:0] YLAST = 7'(YMAX);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_INIT,
    S_PLOT_LOAD,
    S_PLOT_DRAW,
    S_STEP_Y,
    S_DECIDE,
    S_CRIT,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] clr_x_q, clr_x_d;
  logic [6:0] clr_y_q, clr_y_d;
  logic       dec_q, dec_d;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      clr_x_q <= '0;
      clr_y_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_x_q <= clr_x_d;
      clr_y_q <= clr_y_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_x_d = clr_x_q;
    clr_y_d = clr_y_q;
    dec_d   = dec_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (clear_en) begin
            state_d = S_CLEAR;
            clr_x_d = '0;
            clr_y_d = '0;
          end else begin
            state_d = S_INIT;
          end
        end
      end
      S_CLEAR: begin
        if (clr_x_q == XLAST) begin
          clr_x_d = '0;
          if (clr_y_q == YLAST) begin
            clr_y_d = '0;
            state_d = S_INIT;
          end else begin
            clr_y_d = clr_y_q + 7'd1;
          end
        end else begin
          clr_x_d = clr_x_q + 8'd1;
        end
      end
      S_INIT:      state_d = S_PLOT_LOAD;
      S_PLOT_LOAD: state_d = S_PLOT_DRAW;
      // oct_last reflects the octant being drawn now, before oct_en advances it
      S_PLOT_DRAW: state_d = oct_last ? S_STEP_Y : S_PLOT_LOAD;
      S_STEP_Y: begin
        dec_d   = crit_pos;
        state_d = S_DECIDE;
      end
      S_DECIDE:    state_d = S_CRIT;
      S_CRIT:      state_d = loop_done ? S_DONE : S_PLOT_LOAD;
      S_DONE:      if (!start) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    init     = 1'b0;
    xy_load  = 1'b0;
    oct_en   = 1'b0;
    oct_clr  = 1'b0;
    y_off_en = 1'b0;
    x_off_en = 1'b0;
    crit_en  = 1'b0;
    crit_sel = 1'b0;
    pix_sel  = 1'b0;
    plot     = 1'b0;
    done     = 1'b0;
    clr_x    = clr_x_q;
    clr_y    = clr_y_q;
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    unique case (state_q)
      S_CLEAR: begin
        pix_sel = 1'b1;
        plot    = 1'b1;
      end
      S_INIT:      init = 1'b1;
      S_PLOT_LOAD: xy_load = 1'b1;
      S_PLOT_DRAW: begin
        plot   = 1'b1;
        oct_en = 1'b1;
      end
      S_STEP_Y:    y_off_en = 1'b1;
      S_DECIDE:    x_off_en = dec_q;
      S_CRIT: begin
        crit_en  = 1'b1;
        crit_sel = ~dec_q;
        oct_clr  = 1'b1;
      end
      S_DONE:      done = 1'b1;
      default: ;
    endcase
  end

endmodule
